// File: rtl/sha256_job_scheduler.sv
// Round-robin job scheduler sharing one SHA-256 core among NUM_REQ requesters.
// Optional job counter output enabled by defining SHA_SCHED_STATS_EN.
`timescale 1ns/1ps
module sha256_job_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_msg_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_out_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cmpl_valid,
    output logic [2:0]                cmpl_id,
    output logic                      busy,
    output logic                      core_start,
    output logic [ADDR_W-1:0]         core_message_addr,
    output logic [ADDR_W-1:0]         core_output_addr,
    input  logic                      core_done
`ifdef SHA_SCHED_STATS_EN
    ,
    output logic [15:0]               job_count
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        CMPL    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           winner_q, winner_d;
    logic [ADDR_W-1:0]    msg_q, msg_d;
    logic [ADDR_W-1:0]    out_q, out_d;
    logic                 core_start_q, core_start_d;
    logic                 busy_q, busy_d;
    logic                 cmpl_valid_q, cmpl_valid_d;
    logic [2:0]           cmpl_id_q, cmpl_id_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;

    logic                 pick_found_s;
    logic [2:0]           pick_id_s;
    logic [ADDR_W-1:0]    pick_msg_s;
    logic [ADDR_W-1:0]    pick_out_s;

    // Returns {found, index}; the lowest offset from ptr wins, so scan downward.
    function automatic logic [3:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [2:0] ptr);
        logic [7:0] v8;
        logic [3:0] idx;
        logic [3:0] res;
        v8  = 8'(v);
        res = 4'b0000;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(NUM_REQ)) begin
                idx = idx - 4'(NUM_REQ);
            end else begin
                idx = idx;
            end
            if (v8[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration winner and its address slices.
    always_comb begin
        {pick_found_s, pick_id_s} = rr_pick(req_valid, rr_ptr_q);
        pick_msg_s = {ADDR_W{1'b0}};
        pick_out_s = {ADDR_W{1'b0}};
        for (int r = 0; r < NUM_REQ; r++) begin
            if (pick_id_s == 3'(r)) begin
                pick_msg_s = req_msg_addr[r*ADDR_W +: ADDR_W];
                pick_out_s = req_out_addr[r*ADDR_W +: ADDR_W];
            end else begin
                pick_msg_s = pick_msg_s;
                pick_out_s = pick_out_s;
            end
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        msg_d    = msg_q;
        out_d    = out_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s && core_done) begin
                    state_d  = ISSUE;
                    winner_d = pick_id_s;
                    rr_ptr_d = (pick_id_s == 3'(NUM_REQ - 1)) ? 3'd0 : pick_id_s + 3'd1;
                    msg_d    = pick_msg_s;
                    out_d    = pick_out_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   state_d = WAIT_LO;
            WAIT_LO: begin
                if (!core_done) begin
                    state_d = WAIT_HI;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_HI: begin
                if (core_done) begin
                    state_d = CMPL;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            CMPL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        core_start_d = (state_d == ISSUE);
        busy_d       = (state_d != IDLE);
        cmpl_valid_d = (state_d == CMPL);
        cmpl_id_d    = (state_d == CMPL) ? winner_d : cmpl_id_q;
        req_ready_d  = {NUM_REQ{1'b0}};
        for (int r = 0; r < NUM_REQ; r++) begin
            req_ready_d[r] = (state_d == ISSUE) && (winner_d == 3'(r));
        end
    end

    // State, pointer, latched job and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 3'd0;
            winner_q     <= 3'd0;
            msg_q        <= {ADDR_W{1'b0}};
            out_q        <= {ADDR_W{1'b0}};
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            cmpl_valid_q <= 1'b0;
            cmpl_id_q    <= 3'd0;
            req_ready_q  <= {NUM_REQ{1'b0}};
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            winner_q     <= winner_d;
            msg_q        <= msg_d;
            out_q        <= out_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            cmpl_valid_q <= cmpl_valid_d;
            cmpl_id_q    <= cmpl_id_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign core_start        = core_start_q;
    assign busy              = busy_q;
    assign cmpl_valid        = cmpl_valid_q;
    assign cmpl_id           = cmpl_id_q;
    assign req_ready         = req_ready_q;
    assign core_message_addr = msg_q;
    assign core_output_addr  = out_q;

`ifdef SHA_SCHED_STATS_EN
    logic [15:0] job_count_q;

    // Completed-job counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            job_count_q <= 16'd0;
        end else if (cmpl_valid_q) begin
            job_count_q <= job_count_q + 16'd1;
        end else begin
            job_count_q <= job_count_q;
        end
    end

    assign job_count = job_count_q;
`endif

endmodule

// File: doc/sha256_job_scheduler.md
SHA256_JOB_SCHEDULER -- requirements
Module: sha256_job_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, meaning number of requesters sharing one SHA-256 core; legal 2..8.
REQ-002 Parameter ADDR_W, default 16, meaning width of message/output word addresses.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester job request, held until accepted.
REQ-006 req_msg_addr  input  NUM_REQ*ADDR_W  per-requester message base address; slice r = bits [r*ADDR_W +: ADDR_W].
REQ-007 req_out_addr  input  NUM_REQ*ADDR_W  per-requester hash output base address; same slicing.
REQ-008 req_ready  output  NUM_REQ  one-hot acceptance pulse.
REQ-009 cmpl_valid  output  1  one-cycle job-complete pulse.
REQ-010 cmpl_id  output  3  index of the completed requester; valid with cmpl_valid.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 core_start  output  1  one-cycle start pulse to the core.
REQ-013 core_message_addr  output  ADDR_W  latched message address for the core.
REQ-014 core_output_addr  output  ADDR_W  latched output address for the core.
REQ-015 core_done  input  1  core idle indicator; high in core IDLE, low while hashing.

Function
REQ-016 States IDLE, ISSUE, WAIT_LO, WAIT_HI, CMPL; all outputs registered.
REQ-017 IDLE: if any req_valid bit and core_done=1, grant winner, latch its two addresses onto core_*_addr, store winner id, go to ISSUE; otherwise stay.
REQ-018 Arbitration round-robin: search starts at pointer rr_ptr, ascending, wrapping from NUM_REQ-1 to 0; on grant rr_ptr becomes (winner+1) mod NUM_REQ.
REQ-019 ISSUE (one cycle): core_start=1 and req_ready[winner]=1; go to WAIT_LO.
REQ-020 WAIT_LO: stay until core_done=0, then go to WAIT_HI (core drops done one cycle after start).
REQ-021 WAIT_HI: stay until core_done=1, then go to CMPL.
REQ-022 CMPL (one cycle): cmpl_valid=1, cmpl_id=winner; go to IDLE.
REQ-023 Minimum grant-to-grant spacing: 5 cycles plus core run time; back-to-back jobs allowed from IDLE on the cycle after CMPL.
REQ-024 core_*_addr hold stable from ISSUE through CMPL regardless of req_* changes.
REQ-025 req_valid deasserted before grant: request not served, no error.
REQ-026 core_done=0 while in IDLE (core busy from elsewhere or not yet reset): no grant issued.
REQ-027 Requests from the just-served requester rank last in the next arbitration.

Reset
REQ-028 On reset_n low: state IDLE, rr_ptr 0, core_start 0, req_ready 0, cmpl_valid 0, cmpl_id 0, busy 0, core_message_addr 0, core_output_addr 0.
REQ-029 Reset mid-job abandons the job; no cmpl_valid issued for it; the first grant after release requires core_done=1.

Configuration
REQ-030 Macro SHA_SCHED_STATS_EN defined: extra output port job_count (16 bits) increments by 1 on every cycle cmpl_valid=1, wraps 16'hFFFF to 0, resets to 0.
REQ-031 Macro SHA_SCHED_STATS_EN undefined: job_count port and counter absent; all other behaviour identical.

Verification
REQ-032 Single job: req_valid=4'b0001, msg=16'h0000, out=16'h0100, core model busy 150 cycles -> core_start one pulse, core_message_addr=16'h0000, core_output_addr=16'h0100, req_ready=4'b0001, then cmpl_valid with cmpl_id=0.
REQ-033 All four requesting continuously from reset -> grant order 0,1,2,3,0; each cmpl_id matches.
REQ-034 core_done held 0 for 50 cycles after reset with req_valid=4'b0100 -> no core_start until core_done=1; then grant id 2.
REQ-035 reset_n pulsed low during WAIT_HI -> all outputs at reset values, no cmpl_valid; next request served with rr_ptr=0 priority.
REQ-036 req_valid[1] dropped during WAIT_LO for job on id 3 -> addresses unchanged, completion id 3, id 1 not granted.
REQ-037 With SHA_SCHED_STATS_EN, 3 completed jobs -> job_count=3; preloaded to 16'hFFFF plus one job -> job_count=0.
